// File: rtl/core_pkg.sv
// Shared definitions for the front-end queue: sizing constants, the entry
// record stored per instruction, and a small population-count helper.
package core_pkg;

  localparam int DEPTH        = 16;
  localparam int FETCH_WIDTH  = 4;
  localparam int DECODE_WIDTH = 4;
  localparam int ILEN         = 32;
  localparam int XLEN         = 32;

  localparam int FB_PTR_W = $clog2(DEPTH);
  localparam int FB_CNT_W = FB_PTR_W + 1;

  // popcnt works on the wider of the two masks; narrower masks are zero-extended.
  localparam int POP_IN_W  = (FETCH_WIDTH > DECODE_WIDTH) ? FETCH_WIDTH : DECODE_WIDTH;
  localparam int POP_OUT_W = $clog2(POP_IN_W + 1);

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } fbEntry_t;

  function automatic logic [POP_OUT_W-1:0] popcnt(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      n = n + POP_OUT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and decode.
//
// Handshake: fetch offers a group whenever i_enq_vld != 0; the group is taken
// whole in any cycle where o_enq_rdy is high and no squash is present, and
// fetch must hold it (retry) otherwise. o_enq_rdy depends only on registered
// occupancy. Decode sees the oldest entries as o_inst_vld slots and pops a
// prefix of them with i_can_deq; the pop takes effect at the clock edge.
// A squash empties the queue, discarding that cycle's enqueue and dequeue.
module fetch_buffer
  import core_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_squash_vld,
  input  logic [FETCH_WIDTH-1:0]              i_enq_vld,
  input  logic [FETCH_WIDTH-1:0][ILEN-1:0]    i_enq_inst,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]    i_enq_pc,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0]    i_enq_npc,
  output logic                                o_enq_rdy,
  input  logic [DECODE_WIDTH-1:0]             i_can_deq,
  output logic [DECODE_WIDTH-1:0]             o_inst_vld,
  output logic [DECODE_WIDTH-1:0][ILEN-1:0]   o_inst,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]   o_inst_pc,
  output logic [DECODE_WIDTH-1:0][XLEN-1:0]   o_inst_npc
);

  // Ready while at least one full fetch group of space remains.
  localparam logic [FB_CNT_W-1:0] ENQ_RDY_MAX = FB_CNT_W'(DEPTH - FETCH_WIDTH);

  logic [FB_PTR_W-1:0]  head;
  logic [FB_PTR_W-1:0]  tail;
  logic [FB_CNT_W-1:0]  count;
  fbEntry_t             fb_buf [DEPTH];

  logic                 enq_fire;
  logic                 deq_fire;
  logic [POP_OUT_W-1:0] n_enq;
  logic [POP_OUT_W-1:0] n_deq;

  assign o_enq_rdy = (count <= ENQ_RDY_MAX);
  assign enq_fire  = o_enq_rdy && (|i_enq_vld) && !i_squash_vld;
  assign deq_fire  = (|i_can_deq) && !i_squash_vld;
  assign n_enq     = enq_fire ? popcnt(POP_IN_W'(i_enq_vld)) : '0;
  assign n_deq     = deq_fire ? popcnt(POP_IN_W'(i_can_deq)) : '0;

  // Pointer and occupancy update; squash collapses the queue to empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_squash_vld) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + FB_PTR_W'(n_deq);
      tail  <= tail + FB_PTR_W'(n_enq);
      count <= count + FB_CNT_W'(n_enq) - FB_CNT_W'(n_deq);
    end
  end

  // Group write: lane k lands at tail+k, wrapping past DEPTH-1 naturally.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (enq_fire && i_enq_vld[k]) begin
        fb_buf[tail + FB_PTR_W'(k)] <= '{inst: i_enq_inst[k], pc: i_enq_pc[k], npc: i_enq_npc[k]};
      end
    end
  end

  // Slot read: slot s shows entry head+s, valid while s is below occupancy.
  always_comb begin
    for (int s = 0; s < DECODE_WIDTH; s++) begin
      o_inst_vld[s] = (FB_CNT_W'(s) < count);
      o_inst[s]     = fb_buf[head + FB_PTR_W'(s)].inst;
      o_inst_pc[s]  = fb_buf[head + FB_PTR_W'(s)].pc;
      o_inst_npc[s] = fb_buf[head + FB_PTR_W'(s)].npc;
    end
  end

  // Protocol checks on the two masks supplied by neighbouring stages.
  a_deq_prefix : assert property (@(posedge clk) disable iff (!rst)
    ((i_can_deq & (i_can_deq + DECODE_WIDTH'(1))) == '0));

  a_deq_in_vld : assert property (@(posedge clk) disable iff (!rst)
    ((i_can_deq & ~o_inst_vld) == '0));

  a_enq_contig : assert property (@(posedge clk) disable iff (!rst)
    ((i_enq_vld & (i_enq_vld + FETCH_WIDTH'(1))) == '0));

endmodule
